// File: rtl/cache_line_mem.sv
// -----------------------------------------------------------------------------
// cache_line_mem
// Line-granular backing memory behind an L1 cache miss engine. Each request
// moves one 128-bit line. After a fixed LATENCY the block answers with a
// one-cycle mem_ready pulse. It also serves as the bench memory for cache
// regressions.
//
// Parameters
//   LATENCY  cycles from the request capture edge to the mem_ready cycle (1..255)
//   IDX_W    line index width; DEPTH = 2**IDX_W lines
//
// Ports
//   clk         clock; all state changes on posedge
//   proc_reset  synchronous active-high reset
//   mem_read    line read request, held until mem_ready
//   mem_write   line write request, held until mem_ready
//   mem_addr    line address; only the low IDX_W bits select a line (aliasing)
//   mem_wdata   write line data
//   mem_rdata   read line data; registered, holds the last read value
//   mem_ready   registered one-cycle completion pulse
//   rd_cnt      completed reads, saturating
//   wr_cnt      completed writes, saturating
//   proto_err   sticky flag: read and write were both requested at capture
// -----------------------------------------------------------------------------
module cache_line_mem #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDX_W   = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt,
  output logic         proto_err
);

  localparam int unsigned DEPTH    = 1 << IDX_W;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);
  localparam bit          LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [7:0]         cnt_q;
  logic               op_wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;
  logic               mem_ready_q;
  logic [127:0]       rdata_q;
  logic [15:0]        rd_cnt_q;
  logic [15:0]        wr_cnt_q;
  logic               proto_err_q;

  // Line storage. Not cleared by reset; benches preload it.
  logic [127:0]       mem_q [DEPTH];

  logic               req;
  logic [IDX_W-1:0]   req_idx;
  logic [7:0]         cnt_d;
  logic               busy_done;
  logic               enter_resp;
  logic               enter_rd;
  logic [IDX_W-1:0]   rd_idx;
  logic               unused_addr;

  assign req         = mem_read | mem_write;
  assign req_idx     = mem_addr[IDX_W-1:0];
  assign unused_addr = ^mem_addr[27:IDX_W];

  // In BUSY the counter steps down once per cycle and the FSM moves to RESP
  // on the edge where it reaches zero. This gives LATENCY-1 BUSY cycles, so
  // RESP is the LATENCY-th cycle after the capture edge.
  assign cnt_d     = cnt_q - 8'd1;
  assign busy_done = (state_q == S_BUSY) && (cnt_d == 8'd0);

  // With LATENCY==1 the capture edge goes straight into RESP.
  assign enter_resp = busy_done || ((state_q == S_IDLE) && req && LAT_ONE);

  // A read is the captured op in BUSY, or a read-only request when capture and
  // RESP entry share an edge. A simultaneous read+write is treated as a write.
  assign enter_rd = enter_resp &&
                    ((state_q == S_IDLE) ? (mem_read && !mem_write) : !op_wr_q);
  assign rd_idx   = (state_q == S_IDLE) ? req_idx : idx_q;

  // Control FSM. All outputs are registered, so mem_ready has no
  // combinational path from the request inputs.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      mem_ready_q <= 1'b0;
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
      proto_err_q <= 1'b0;
    end else begin
      mem_ready_q <= enter_resp;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_wr_q     <= mem_write;
            idx_q       <= req_idx;
            wdata_q     <= mem_wdata;
            cnt_q       <= CNT_INIT;
            proto_err_q <= proto_err_q | (mem_read & mem_write);
            state_q     <= LAT_ONE ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_d;
          if (busy_done) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (op_wr_q) begin
            if (wr_cnt_q != 16'hFFFF) begin
              wr_cnt_q <= wr_cnt_q + 16'd1;
            end
          end else begin
            if (rd_cnt_q != 16'hFFFF) begin
              rd_cnt_q <= rd_cnt_q + 16'd1;
            end
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Registered read port: the line is sampled on the edge entering RESP and
  // then held until the next read completes.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      rdata_q <= '0;
    end else if (enter_rd) begin
      rdata_q <= mem_q[rd_idx];
    end
  end

  // Write port: commits on the edge leaving RESP. A reset on that edge drops
  // the write, like any other pending op.
  always_ff @(posedge clk) begin
    if ((state_q == S_RESP) && op_wr_q && !proc_reset) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = mem_ready_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = proto_err_q;

endmodule
